// File: rtl/nios_system_de2_pio_key_in.sv
// Avalon-MM input PIO for DE2 keys/switches.
// Synchronises and debounces inputs, captures edges, raises a masked irq.
module nios_system_de2_pio_key_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic          r_deb;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_cnt <= '0;
        r_deb <= 1'b1;
      end else if (r_sync2[gi] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[gi]    = r_deb;
    assign w_accept[gi] = (r_sync2[gi] != r_deb) && (r_cnt == CNT_LAST);

    // Qualify the accepted level change by the configured edge direction.
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_set[gi] = w_accept[gi] & r_sync2[gi];
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_set[gi] = w_accept[gi] & ~r_sync2[gi];
    end else begin : g_any
      assign w_set[gi] = w_accept[gi];
    end
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_edge <= '0;
      r_mask <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr && address == 2'd2) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (address)
      2'd0: w_rdata[WIDTH-1:0] = w_deb;
      2'd1: w_rdata[WIDTH-1:0] = r_sync2;
      2'd2: w_rdata[WIDTH-1:0] = r_mask;
      2'd3: w_rdata[WIDTH-1:0] = r_edge;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign readdata = r_rdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_nios_system_de2_pio_key_in.sv
// Directed bench for the key-input PIO.
// DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_nios_system_de2_pio_key_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  nios_system_de2_pio_key_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int wr;
    int addr;
    int wd;
    int inp;
    int crd;
    int erd;
    int cirq;
    int eirq;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(int rst, int wr, int a, int wd, int inp,
                             int crd, int erd, int cirq, int eirq);
    vec_t r;
    r.rst = rst; r.wr = wr; r.addr = a; r.wd = wd; r.inp = inp;
    r.crd = crd; r.erd = erd; r.cirq = cirq; r.eirq = eirq;
    return r;
  endfunction

  // Drive at a falling edge, let one rising edge pass, check at next fall.
  task automatic step(input int rst, input int wr, input int a,
                      input int wd, input int inp, input int crd,
                      input int erd, input int cirq, input int eirq,
                      input string nm);
    reset_n    = (rst == 0);
    chipselect = 1'b1;
    write_n    = (wr == 0);
    address    = 2'(a);
    writedata  = 32'(wd);
    in_port    = 4'(inp);
    @(negedge clk);
    if (crd != 0) begin
      total++;
      if (readdata !== 32'(erd)) begin
        bad++;
        $display("FAIL %s readdata got=%h exp=%h", nm, readdata, 32'(erd));
      end
    end
    if (cirq != 0) begin
      total++;
      if (irq !== 1'(eirq)) begin
        bad++;
        $display("FAIL %s irq got=%b exp=%b", nm, irq, 1'(eirq));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in_port = 4'hF;

    // reset readback and falling-edge capture
    tv.push_back(v(1,0,0,0,'hF, 1,'h0, 1,0));
    tv.push_back(v(1,0,0,0,'hF, 1,'h0, 1,0));
    tv.push_back(v(0,0,0,0,'hF, 1,'hF, 1,0));
    tv.push_back(v(0,0,1,0,'hF, 1,'hF, 0,0));
    tv.push_back(v(0,0,2,0,'hF, 1,'h0, 0,0));
    tv.push_back(v(0,0,3,0,'hF, 1,'h0, 1,0));
    tv.push_back(v(0,1,2,1,'hF, 0,'h0, 1,0));
    tv.push_back(v(0,0,2,0,'hF, 1,'h1, 1,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(v(0,0,3,0,'hE, 1,'h0, 1,0));
    tv.push_back(v(0,0,3,0,'hE, 1,'h0, 1,1));
    tv.push_back(v(0,0,3,0,'hE, 1,'h1, 1,1));
    tv.push_back(v(0,0,0,0,'hE, 1,'hE, 1,1));
    tv.push_back(v(0,1,3,1,'hE, 1,'h1, 1,0));
    tv.push_back(v(0,0,3,0,'hE, 1,'h0, 1,0));

    // glitch on bit 1 for three cycles
    tv.push_back(v(1,0,1,0,'hF, 0,'h0, 0,0));
    tv.push_back(v(0,0,1,0,'hD, 1,'hF, 0,0));
    tv.push_back(v(0,0,1,0,'hD, 1,'hF, 0,0));
    tv.push_back(v(0,0,1,0,'hD, 1,'hD, 0,0));
    tv.push_back(v(0,0,1,0,'hF, 1,'hD, 0,0));
    tv.push_back(v(0,0,1,0,'hF, 1,'hD, 0,0));
    tv.push_back(v(0,0,1,0,'hF, 1,'hF, 0,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(v(0,0,0,0,'hF, 1,'hF, 1,0));
    tv.push_back(v(0,0,3,0,'hF, 1,'h0, 1,0));
    tv.push_back(v(0,0,3,0,'hF, 1,'h0, 1,0));

    // masked-off capture on key 2, then unmask
    tv.push_back(v(1,0,3,0,'hF, 0,'h0, 0,0));
    for (int i = 0; i < 6; i++)
      tv.push_back(v(0,0,3,0,'hB, 1,'h0, 1,0));
    tv.push_back(v(0,0,3,0,'hB, 1,'h4, 1,0));
    tv.push_back(v(0,1,2,4,'hB, 1,'h0, 1,1));
    tv.push_back(v(0,0,2,0,'hB, 1,'h4, 1,1));

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++)
      step(tv[i].rst, tv[i].wr, tv[i].addr, tv[i].wd, tv[i].inp,
           tv[i].crd, tv[i].erd, tv[i].cirq, tv[i].eirq,
           $sformatf("vec%0d", i));

    // clear write lands on the same edge bit 3 is accepted
    step(1,0,3,0,'hF, 0,0, 0,0, "col_rst");
    step(0,1,2,8,'hF, 0,0, 1,0, "col_mask");
    for (int i = 0; i < 5; i++)
      step(0,0,3,0,'h7, 1,0, 1,0, $sformatf("col_wait%0d", i));
    step(0,1,3,8,'h7, 1,0, 1,1, "col_hit");
    step(0,0,3,0,'h7, 1,8, 1,1, "col_keep");
    step(0,1,3,8,'h7, 1,8, 1,0, "col_clr");
    step(0,0,3,0,'h7, 1,0, 1,0, "col_gone");

    // reset while bit 3 is part-way through its debounce
    step(1,0,0,0,'hF, 0,0, 0,0, "mid_rst0");
    for (int i = 0; i < 4; i++)
      step(0,0,3,0,'h7, 1,0, 0,0, $sformatf("mid_cnt%0d", i));
    step(1,0,0,0,'h7, 1,0, 1,0, "mid_rst");
    step(0,0,0,0,'h7, 1,'hF, 0,0, "mid_deb");
    for (int i = 0; i < 5; i++)
      step(0,0,3,0,'h7, 1,0, 0,0, $sformatf("mid_wait%0d", i));
    step(0,0,3,0,'h7, 1,8, 0,0, "mid_acc");
    step(0,0,0,0,'h7, 1,7, 0,0, "mid_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_system_de2_pio_key_in.md
# nios_system_de2_pio_key_in

Avalon-MM slave input PIO for the DE2 pushbuttons and switches: the read-side counterpart of the hex-display output PIOs. It synchronises and debounces `in_port`, exposes the debounced level, per-bit edge-capture and interrupt-mask registers to the Nios II, and raises `irq` on captured edges. It sits on the system interconnect beside the hex output PIOs and uses the same 2-bit word address and 32-bit data bus.

## Interface
- `WIDTH`, 4: number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles before a level change is accepted (1 ms at 50 MHz); minimum 1.
- `EDGE_TYPE`, 1: edge to capture. 0 = rising, 1 = falling (DE2 keys are active-low), 2 = any.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `address` in 2: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous external inputs.
- `readdata` out 32: registered read data; bits above WIDTH are 0.
- `irq` out 1: level interrupt to Nios II.

## Operation
- Register map:
  - 0 DATA (RO): debounced level.
  - 1 RAW (RO): synchroniser output, not debounced.
  - 2 IRQ_MASK (RW): `writedata[WIDTH-1:0]`.
  - 3 EDGECAPTURE (RO / write-1-to-clear).
- Writes to addresses 0 and 1 are ignored.
- A write is `chipselect && !write_n` sampled at a rising edge.
- Synchroniser: two flops per bit (`sync1`, `sync2`).
- Debouncer: one counter per bit, width `$clog2(DEBOUNCE_CYCLES+1)`, with `deb` holding the accepted level. Per bit, each cycle:
  - If `sync2 == deb`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= sync2`, `cnt <= 0`, and an accept event fires for that bit.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles resets the count and never changes `deb`.
- Edge qualification at an accept event:
  - rising: `sync2 == 1`.
  - falling: `sync2 == 0`.
  - any: always.
  - A qualified event sets `edgecapture[i]` in the same cycle that `deb` updates.
- EDGECAPTURE clear: a write to address 3 clears the bits where `writedata` is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq = |(edgecapture & irq_mask)`. It is combinational from flops, with no extra register stage.
- `readdata` is registered every cycle from the address mux, regardless of `chipselect`. Unmapped bits are 0.
- Reset (`reset_n` low at a rising edge): the following values apply, and any debounce in progress is discarded.
  - `sync1`, `sync2`, `deb` all ones (keys idle high).
  - counters, `edgecapture`, `irq_mask`, `readdata` all 0.
  - `irq` 0.

## Timing
- Read latency is 1. Address presented at edge n produces `readdata` valid after edge n+1.
- Input path: suppose `in_port[i]` changes before edge k and is then held stable.
  - `sync2` updates at edge k+1.
  - `deb` and `edgecapture` update at edge k+DEBOUNCE_CYCLES+1.
  - `irq` asserts immediately after that edge if the bit is masked in.
  - DATA is visible on `readdata` one edge later.
- Mask write at edge n: `irq` reflects the new mask after edge n.
- Clear write at edge n: the `edgecapture` bit and `irq` drop after edge n, unless a new edge is accepted at the same edge.
- Bits debounce independently. Simultaneous accepts on several bits set all of them in the same cycle.
- When `in_port` toggles every cycle, the counter keeps restarting and no accept occurs.

## Test plan
- Reset sequence: hold `reset_n` low for 2 cycles with `in_port`=4'hF. Then read addresses 0–3 → 0xF, 0xF, 0x0, 0x0; `irq`=0.
- Falling-edge capture (`DEBOUNCE_CYCLES`=4, `EDGE_TYPE`=1, mask=4'h1): drive `in_port`=4'hE before edge k.
  - `edgecapture`=0x1 and `irq`=1 after edge k+5.
  - Address 0 reads 0xE.
  - Writing 0x1 to address 3 clears `edgecapture` and drops `irq`.
- Glitch rejection (`DEBOUNCE_CYCLES`=4): pulse bit 1 low for 3 cycles, then high again. Address 0 stays 0xF, `edgecapture` stays 0, while address 1 shows 0xD during the pulse.
- Masking: with mask=0, press key 2 → `edgecapture`=0x4 and `irq`=0. Write mask 0x4 → `irq`=1 after that edge.
- Set/clear collision: time a write of 0x8 to address 3 on the exact edge bit 3 is accepted → `edgecapture[3]` remains 1.
- Reset mid-debounce: assert `reset_n` low at count 2 of 4 while `in_port`=4'h7. After release, `deb`=0xF and the counter restarts from 0. Bit 3 is then accepted 5 edges after release, with `edgecapture`=0x8.
